// File: rtl/ula_pkg.sv
// ula_pkg: opcode and state encodings plus the default width shared by the ula_seq files.
package ula_pkg;
  localparam int BITS_DEF = 63;
  typedef enum logic [2:0] {
    OP_SUB  = 3'b000,
    OP_ADD  = 3'b001,
    OP_EQU  = 3'b010,
    OP_SLT  = 3'b011,
    OP_SLTU = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_MUL  = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MULT,
    S_DONE
  } state_e;
endpackage

// File: rtl/ula_seq_if.sv
// ula_seq_if: start/busy/done request bus between a controller and the sequential ALU.
interface ula_seq_if import ula_pkg::*; #(parameter int BITS = BITS_DEF);
  logic          start;
  op_e           op;
  logic [BITS:0] a;
  logic [BITS:0] b;
  logic          busy;
  logic          done;
  logic [BITS:0] result;
  logic          v;
  logic          zero;
  modport master (output start, op, a, b, input busy, done, result, v, zero);
  modport slave (input start, op, a, b, output busy, done, result, v, zero);
endinterface

// File: rtl/ula_mul_step.sv
// ula_mul_step: one combinational shift-add multiply step and its end-of-iteration compare.
module ula_mul_step #(parameter int BITS = ula_pkg::BITS_DEF) (
  input  logic [BITS:0]               acc_i,
  input  logic [BITS:0]               mcand_i,
  input  logic [BITS:0]               mplier_i,
  input  logic [$clog2(BITS+2)-1:0]   cnt_i,
  output logic [BITS:0]               acc_o,
  output logic [BITS:0]               mcand_o,
  output logic [BITS:0]               mplier_o,
  output logic [$clog2(BITS+2)-1:0]   cnt_o,
  output logic                        last_o
);
  localparam int CW = $clog2(BITS + 2);
  assign acc_o    = mplier_i[0] ? acc_i + mcand_i : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;
  assign cnt_o    = cnt_i + CW'(1);
  assign last_o   = cnt_i == CW'(BITS + 1);
endmodule

// File: rtl/ula_seq.sv
// ula_seq: registered two's-complement ALU with single-cycle ops and an iterative shift-add multiply.
module ula_seq import ula_pkg::*; #(parameter int BITS = BITS_DEF) (
  input logic       clock,
  input logic       reset,
  ula_seq_if.slave  bus
);
  localparam int CW = $clog2(BITS + 2);
  state_e        state_q, state_d;
  op_e           op_q;
  logic [BITS:0] a_q, b_q, acc_q, result_q;
  logic [BITS:0] a_d, b_d, acc_d;
  logic [BITS:0] sum, diff, alu_res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          v_q, zero_q, alu_v, last;
  ula_mul_step #(.BITS(BITS)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (a_q),
    .mplier_i (b_q),
    .cnt_i    (cnt_q),
    .acc_o    (acc_d),
    .mcand_o  (a_d),
    .mplier_o (b_d),
    .cnt_o    (cnt_d),
    .last_o   (last)
  );
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_q)
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (a_q[BITS] != b_q[BITS]) && (diff[BITS] != a_q[BITS]);
      end
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (a_q[BITS] == b_q[BITS]) && (sum[BITS] != a_q[BITS]);
      end
      OP_EQU:  alu_res = {{BITS{1'b0}}, a_q == b_q};
      OP_SLT:  alu_res = {{BITS{1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: alu_res = {{BITS{1'b0}}, a_q < b_q};
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clock) state_q <= reset ? S_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? (bus.op == OP_MUL ? S_MULT : S_EXEC) : S_IDLE;
      S_EXEC:  state_d = S_DONE;
      S_MULT:  state_d = last ? S_DONE : S_MULT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.busy   = state_q != S_IDLE;
    bus.done   = state_q == S_DONE;
    bus.result = result_q;
    bus.v      = v_q;
    bus.zero   = zero_q;
  end
  // a_q/b_q double as multiplicand/multiplier and are shifted in place during MULT
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= OP_SUB;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      zero_q   <= 1'b0;
    end else if (state_q == S_IDLE && bus.start) begin
      op_q  <= bus.op;
      a_q   <= bus.a;
      b_q   <= bus.b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_res;
      v_q      <= alu_v;
      zero_q   <= alu_res == '0;
    end else if (state_q == S_MULT && last) begin
      result_q <= acc_q;
      v_q      <= 1'b0;
      zero_q   <= acc_q == '0;
    end else if (state_q == S_MULT) begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Registered, parametrised-width two's-complement ALU for the datapath.
- Extends the SUB/ADD/EQU/SLT operation set with unsigned compare, bitwise AND/OR, and an iterative multi-cycle multiply.
- Uses a start/busy/done handshake, so the controller FSM can issue an operation and wait for completion.

Parameters:
- BITS, 63, MSB index of operands and result; data width is BITS+1.
- SUB, 3'b000, opcode: a - b.
- ADD, 3'b001, opcode: a + b.
- EQU, 3'b010, opcode: result = (a == b).
- SLT, 3'b011, opcode: result = (a < b), signed.
- SLTU, 3'b100, opcode: result = (a < b), unsigned.
- AND, 3'b101, opcode: a & b.
- OR, 3'b110, opcode: a | b.
- MUL, 3'b111, opcode: low BITS+1 bits of a*b.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  opcode; sampled with start.
- a  in  BITS+1  operand A, signed; sampled with start.
- b  in  BITS+1  operand B, signed; sampled with start.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse; result, v and zero are valid in this cycle.
- result  out  BITS+1  registered result.
- v  out  1  registered two's-complement overflow.
- zero  out  1  registered flag, result == 0.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; result, v, zero, done, busy = 0.
  - Internal accumulator, operand copies and step counter are cleared.
  - Reset mid-MUL aborts the operation; no done pulse is produced.
- States:
  - IDLE: start=1 with op != MUL → EXEC. start=1 with op == MUL → MULT (accumulator = 0, counter = 0, a/b latched). start=0 → stay.
  - EXEC: compute from the latched operands; register result/v/zero → DONE.
  - MULT: one shift-add step per cycle. If multiplier bit0 = 1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++. After BITS+1 steps → DONE with result = accumulator.
  - DONE: done=1 for exactly one cycle → IDLE.
- Latency, measured from the edge that samples start to the cycle where done=1:
  - non-MUL ops: 2 cycles.
  - MUL: BITS+3 cycles.
- Throughput: a new start is accepted on the first IDLE cycle after DONE. start is ignored while busy=1.
- result, v and zero hold their values after done until the next operation completes.
- Arithmetic: wrap modulo 2^(BITS+1). EQU, SLT and SLTU return 1 or 0, zero-extended.
- Overflow v:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
  - All other ops: v = 0. MUL returns the truncated low half and does not flag overflow.
- MUL sign handling: the low half of the product is identical for signed and unsigned operands, so no sign correction is applied.
- Undefined inputs outside a start cycle have no effect.

Decomposition:
- Shared package ula_pkg holds:
  - the op encodings (SUB…MUL);
  - the state encoding (IDLE, EXEC, MULT, DONE);
  - the default width constant.
- One natural sub-module: ula_mul_step. It is the combinational shift-add step plus its counter compare, and is instantiated in ula_seq.
- Single-cycle ops and the overflow logic stay in the top module.

Test Plan (BITS=7):
- Reset held 2 cycles, mid-MUL → busy=0, done never pulses, result=0, v=0, zero=0.
- ADD a=8'h7F, b=8'h01 → done 2 cycles after start; result=8'h80, v=1, zero=0.
- SUB a=8'h80, b=8'h01 → result=8'h7F, v=1. SUB a=5, b=5 → result=0, zero=1, v=0.
- SLT a=8'hFF, b=8'h01 → result=1. SLTU with the same operands → result=0. EQU 8'h3C/8'h3C → result=1.
- MUL a=8'hFD (-3), b=8'h07 → done exactly 10 cycles after start; result=8'hEB (-21); busy=1 throughout; v=0.
- start pulsed again while MUL busy with op=ADD → ignored; the MUL result is unaffected. A start on the first IDLE cycle after done is accepted.
